// File: rtl/reg_bank_write.sv
// Write side of the r0..r15 register file: commits load and ALU write-backs,
// with a single-entry hold buffer for an ALU write that collides with a load.
`timescale 1ns/1ps
module reg_bank_write #(
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wr_valid,
  output logic              alu_wr_ready,
  input  logic [4:0]        alu_wr_sel,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              ld_wr_valid,
  input  logic [4:0]        ld_wr_sel,
  input  logic [DATA_W-1:0] ld_wr_data,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15,
  output logic              hold_pending,
  output logic              sel_err
);

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } hold_state_e;

  hold_state_e       r_state;
  logic [4:0]        r_hold_sel;
  logic [DATA_W-1:0] r_hold_data;
  logic [DATA_W-1:0] r_regs [16];
  logic              r_sel_err;

  logic              w_alu_accept;
  logic              w_wr_en;
  logic [4:0]        w_wr_sel;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_capture;
  logic              w_release;
  logic              w_sel_err;

  function automatic logic is_reg_sel(input logic [4:0] sel);
    return (sel >= 5'd1) && (sel <= 5'd16);
  endfunction

  function automatic logic is_bad_sel(input logic [4:0] sel);
    return sel >= 5'd17;
  endfunction

  assign w_alu_accept = alu_wr_valid && (r_state == ST_IDLE);

  // At most one commit per cycle: load first, then a held ALU write, then a direct ALU write.
  always_comb begin
    // NOTE: every signal gets a default up front so no path through the ifs infers a latch.
    w_wr_en   = 1'b0;
    w_wr_sel  = ld_wr_sel;
    w_wr_data = ld_wr_data;
    w_capture = 1'b0;
    w_release = 1'b0;
    if (ld_wr_valid) begin
      w_wr_en = 1'b1;
      if (w_alu_accept) begin
        w_capture = 1'b1;
      end else if ((r_state == ST_HELD) && (ld_wr_sel == r_hold_sel) && is_reg_sel(ld_wr_sel)) begin
        w_release = 1'b1;  // younger load overwrites the held target: drop the entry
      end
    end else if (r_state == ST_HELD) begin
      w_wr_en   = 1'b1;
      w_wr_sel  = r_hold_sel;
      w_wr_data = r_hold_data;
      w_release = 1'b1;
    end else if (w_alu_accept) begin
      w_wr_en   = 1'b1;
      w_wr_sel  = alu_wr_sel;
      w_wr_data = alu_wr_data;
    end
    w_sel_err = (ld_wr_valid && is_bad_sel(ld_wr_sel)) || (w_alu_accept && is_bad_sel(alu_wr_sel));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold_sel  <= '0;
      r_hold_data <= '0;
      r_sel_err   <= 1'b0;
      // NOTE: these are architectural flops, not a RAM, so every entry is reset explicitly.
      for (int i = 0; i < 16; i++) r_regs[i] <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the pre-edge values.
      r_sel_err <= w_sel_err;
      if (w_capture) begin
        r_state     <= ST_HELD;
        r_hold_sel  <= alu_wr_sel;
        r_hold_data <= alu_wr_data;
      end else if (w_release) begin
        r_state <= ST_IDLE;
      end
      for (int i = 0; i < 16; i++) begin
        if (w_wr_en && (w_wr_sel == 5'(i + 1))) r_regs[i] <= w_wr_data;
      end
    end
  end

  assign alu_wr_ready = (r_state == ST_IDLE);
  assign hold_pending = (r_state == ST_HELD);
  assign sel_err      = r_sel_err;

  assign r0  = r_regs[0];
  assign r1  = r_regs[1];
  assign r2  = r_regs[2];
  assign r3  = r_regs[3];
  assign r4  = r_regs[4];
  assign r5  = r_regs[5];
  assign r6  = r_regs[6];
  assign r7  = r_regs[7];
  assign r8  = r_regs[8];
  assign r9  = r_regs[9];
  assign r10 = r_regs[10];
  assign r11 = r_regs[11];
  assign r12 = r_regs[12];
  assign r13 = r_regs[13];
  assign r14 = r_regs[14];
  assign r15 = r_regs[15];

endmodule
